// File: rtl/apb_sched_pkg.sv
// Shared types for the APB transfer scheduler: FSM states and the buffered entry format.
package apb_sched_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_WR,
    CHECK,
    RETRY,
    POP
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  dest;
    logic              check_en;
  } entry_t;

endpackage

// File: rtl/apb_sched_fifo.sv
// Synchronous FIFO of scheduler entries; head is read combinationally from the read pointer.
module apb_sched_fifo
  import apb_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_tx_scheduler.sv
// Buffers ALU results and sequences them onto the APB master as writes with optional
// read-back verification and bounded retry.
module apb_tx_scheduler
  import apb_sched_pkg::*;
#(
  parameter int unsigned m         = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [m-1:0]     i_data,
  input  logic             i_data_valid,
  input  logic [1:0]       i_dest,
  input  logic             i_check_en,
  input  logic             i_alu_error,
  output logic             o_ready,
  output logic [m-1:0]     o_apb_data,
  output logic             o_apb_data_ready,
  output logic [1:0]       o_apb_sel,
  output logic             o_apb_check,
  input  logic             i_apb_waiting,
  input  logic             i_apb_done,
  input  logic             i_apb_fail,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic [CNT_W-1:0] o_fail_cnt
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  state_t        state;
  logic [RW-1:0] retry;
  entry_t        din;
  entry_t        head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          drop;

  assign din  = {DATA_W'(i_data), i_dest, i_check_en};
  assign push = i_data_valid && !i_alu_error && o_ready;
  assign drop = i_data_valid && (i_alu_error || !o_ready);
  assign pop  = (state == POP);

  // Ready follows registered occupancy, so a pop cannot free a slot for a same-cycle push.
  assign o_ready = !full;
  assign o_busy  = (count != '0) || (state != IDLE);

  apb_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESET),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Transfer sequencer; APB-facing outputs are updated on entry to each state.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state            <= IDLE;
      retry            <= '0;
      o_apb_data       <= '0;
      o_apb_sel        <= '0;
      o_apb_data_ready <= 1'b0;
      o_apb_check      <= 1'b0;
      o_fail_cnt       <= '0;
    end else begin
      o_apb_data_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty && i_apb_waiting) begin
            state            <= ISSUE;
            o_apb_data_ready <= 1'b1;
            o_apb_data       <= m'(head.data);
            o_apb_sel        <= head.dest;
          end
        end
        ISSUE: state <= WAIT_WR;
        WAIT_WR: begin
          if (i_apb_done) begin
            if (head.check_en) begin
              state       <= CHECK;
              o_apb_check <= 1'b1;
            end else begin
              state <= POP;
            end
          end
        end
        CHECK: begin
          if (i_apb_done) begin
            o_apb_check <= 1'b0;
            if (!i_apb_fail) begin
              state <= POP;
            end else if (retry < RETRY_LIM) begin
              retry <= retry + RW'(1);
              state <= RETRY;
            end else begin
              if (o_fail_cnt != '1) o_fail_cnt <= o_fail_cnt + CNT_W'(1);
              state <= POP;
            end
          end
        end
        RETRY: begin
          if (i_apb_waiting) begin
            state            <= ISSUE;
            o_apb_data_ready <= 1'b1;
          end
        end
        POP: begin
          state      <= IDLE;
          retry      <= '0;
          o_apb_data <= '0;
          o_apb_sel  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of discarded results.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      o_drop_cnt <= '0;
    end else if (drop && (o_drop_cnt != '1)) begin
      o_drop_cnt <= o_drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_apb_tx_scheduler.sv
// Self-checking bench: directed scenarios plus randomized push/drain rounds against a
// transaction-level queue model of the scheduler.
module tb_apb_tx_scheduler;

  localparam int unsigned M         = 8;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_RETRY = 2;
  localparam int unsigned CNT_W     = 8;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic             PCLK = 1'b0;
  logic             PRESET = 1'b0;
  logic [M-1:0]     i_data = '0;
  logic             i_data_valid = 1'b0;
  logic [1:0]       i_dest = '0;
  logic             i_check_en = 1'b0;
  logic             i_alu_error = 1'b0;
  logic             o_ready;
  logic [M-1:0]     o_apb_data;
  logic             o_apb_data_ready;
  logic [1:0]       o_apb_sel;
  logic             o_apb_check;
  logic             i_apb_waiting = 1'b0;
  logic             i_apb_done = 1'b0;
  logic             i_apb_fail = 1'b0;
  logic             o_busy;
  logic [CNT_W-1:0] o_drop_cnt;
  logic [CNT_W-1:0] o_fail_cnt;

  apb_tx_scheduler #(.m(M), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .PCLK             (PCLK),
    .PRESET           (PRESET),
    .i_data           (i_data),
    .i_data_valid     (i_data_valid),
    .i_dest           (i_dest),
    .i_check_en       (i_check_en),
    .i_alu_error      (i_alu_error),
    .o_ready          (o_ready),
    .o_apb_data       (o_apb_data),
    .o_apb_data_ready (o_apb_data_ready),
    .o_apb_sel        (o_apb_sel),
    .o_apb_check      (o_apb_check),
    .i_apb_waiting    (i_apb_waiting),
    .i_apb_done       (i_apb_done),
    .i_apb_fail       (i_apb_fail),
    .o_busy           (o_busy),
    .o_drop_cnt       (o_drop_cnt),
    .o_fail_cnt       (o_fail_cnt)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [M-1:0] data;
    logic [1:0]   dest;
    logic         chk;
  } item_t;

  item_t q[$];
  int    exp_drop = 0;
  int    exp_fail = 0;
  int    total = 0;
  int    bad = 0;
  int    issue_cnt = 0;

  // Independent count of start pulses, sampled mid-cycle.
  always @(negedge PCLK) if (o_apb_data_ready) issue_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [M-1:0] d, input logic [1:0] dst, input logic ce,
                      input logic err);
    item_t it;
    @(negedge PCLK);
    i_data = d; i_dest = dst; i_check_en = ce; i_alu_error = err; i_data_valid = 1'b1;
    if (err || q.size() >= int'(DEPTH)) begin
      if (exp_drop < CNT_MAX) exp_drop++;
    end else begin
      it.data = d; it.dest = dst; it.chk = ce;
      q.push_back(it);
    end
    @(negedge PCLK);
    i_data_valid = 1'b0; i_alu_error = 1'b0;
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    while (!o_apb_data_ready && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    if (!o_apb_data_ready) begin
      check("issue_timeout", o_apb_data_ready, 1);
      n = -1;
    end
  endtask

  // Plays the APB master. mode: 0 random read-back result, 1 always pass, 2 always fail.
  task automatic drain(input int mode);
    item_t e;
    int    n;
    int    att;
    logic  fl;
    i_apb_waiting = 1'b1;
    while (q.size() > 0) begin
      e = q[0];
      att = 0;
      forever begin
        wait_issue(n);
        if (n < 0) begin
          q.delete();
          return;
        end
        att++;
        check("issue_data", o_apb_data, e.data);
        check("issue_sel", o_apb_sel, e.dest);
        check("issue_chk_low", o_apb_check, 0);
        i_apb_waiting = 1'b0;
        @(negedge PCLK);
        check("start_one_cycle", o_apb_data_ready, 0);
        repeat ($urandom_range(0, 3)) @(negedge PCLK);
        i_apb_done = 1'b1;
        i_apb_fail = 1'($urandom_range(0, 1));
        @(negedge PCLK);
        i_apb_done = 1'b0; i_apb_fail = 1'b0;
        if (!e.chk) break;
        check("check_high", o_apb_check, 1);
        check("check_data", o_apb_data, e.data);
        repeat ($urandom_range(0, 3)) @(negedge PCLK);
        fl = (mode == 2) || (mode == 0 && $urandom_range(0, 2) == 0);
        i_apb_done = 1'b1; i_apb_fail = fl;
        @(negedge PCLK);
        i_apb_done = 1'b0; i_apb_fail = 1'b0;
        check("check_released", o_apb_check, 0);
        if (!fl) break;
        if (att == int'(MAX_RETRY) + 1) begin
          if (exp_fail < CNT_MAX) exp_fail++;
          break;
        end
        i_apb_waiting = 1'b1;
      end
      i_apb_waiting = 1'b1;
      void'(q.pop_front());
    end
    repeat (2) @(negedge PCLK);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_ready"}, o_ready, 1);
    check({tag, "_data"}, o_apb_data, 0);
    check({tag, "_sel"}, o_apb_sel, 0);
    check({tag, "_drop"}, o_drop_cnt, exp_drop);
    check({tag, "_fail"}, o_fail_cnt, exp_fail);
  endtask

  initial begin
    int n;
    int snap;
    int nk;

    repeat (2) @(negedge PCLK);
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_apb_data_ready, 0);
    check("rst_chk", o_apb_check, 0);
    check_idle("rst");
    PRESET = 1'b1;

    // Single write, master idle: start pulse one cycle after the push lands.
    i_apb_waiting = 1'b1;
    push(8'hC9, 2'd2, 1'b0, 1'b0);
    check("busy_after_push", o_busy, 1);
    wait_issue(n);
    check("first_latency", n, 1);
    drain(1);
    check_idle("single");

    // Read-back passes first time.
    snap = issue_cnt;
    push(8'h5A, 2'd1, 1'b1, 1'b0);
    drain(1);
    check("pass_issues", issue_cnt - snap, 1);
    check_idle("pass");

    // Read-back always fails: initial issue plus MAX_RETRY re-issues, then abandoned.
    snap = issue_cnt;
    push(8'h3C, 2'd3, 1'b1, 1'b0);
    drain(2);
    check("exhaust_issues", issue_cnt - snap, int'(MAX_RETRY) + 1);
    check_idle("exhaust");

    // Overflow while the master is busy.
    i_apb_waiting = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push(M'(8'h10 + k), 2'(k), 1'b0, 1'b0);
      if (k == 3) check("full_ready", o_ready, 0);
    end
    check("overflow_drop", o_drop_cnt, exp_drop);
    check("overflow_busy", o_busy, 1);
    drain(1);
    check_idle("overflow");

    // ALU error result is discarded; a stray done in IDLE changes nothing.
    push(8'hEE, 2'd0, 1'b0, 1'b1);
    check("alu_err_busy", o_busy, 0);
    check("alu_err_drop", o_drop_cnt, exp_drop);
    i_apb_done = 1'b1;
    @(negedge PCLK);
    i_apb_done = 1'b0;
    @(negedge PCLK);
    check("idle_done_start", o_apb_data_ready, 0);
    check_idle("alu_err");

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      i_apb_waiting = 1'b0;
      nk = $urandom_range(1, 6);
      for (int k = 0; k < nk; k++)
        push(M'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));
      check("rnd_ready", o_ready, (q.size() < int'(DEPTH)));
      check("rnd_drop", o_drop_cnt, exp_drop);
      drain(0);
      check_idle("rnd");
    end

    // Reset asserted while the read-back is in progress.
    i_apb_waiting = 1'b1;
    push(8'h5A, 2'd1, 1'b1, 1'b0);
    wait_issue(n);
    i_apb_waiting = 1'b0;
    @(negedge PCLK);
    i_apb_done = 1'b1;
    @(negedge PCLK);
    i_apb_done = 1'b0;
    check("pre_rst_check", o_apb_check, 1);
    #2 PRESET = 1'b0;
    #1;
    q.delete();
    exp_drop = 0;
    exp_fail = 0;
    check("mid_rst_chk", o_apb_check, 0);
    check("mid_rst_start", o_apb_data_ready, 0);
    check_idle("mid_rst");
    @(negedge PCLK);
    PRESET = 1'b1;
    i_apb_waiting = 1'b1;
    repeat (3) @(negedge PCLK);
    check("post_rst_start", o_apb_data_ready, 0);
    check_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_tx_scheduler.md
Name: apb_tx_scheduler

Overview:
Sequences the APB master. Accepts ALU results tagged with a destination peripheral and buffers them in a small FIFO. Issues each one to the master as a write, optionally followed by a read-back check, and retries on check failure up to a limit. Sits between the ALU output stage and the APB master; drives the master's i_data, i_data_ready, i_protocol_sel and i_data_check inputs.

Parameters:
m, 8, data width (matches APB master m)
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_RETRY, 2, re-issues allowed after a failed check
CNT_W, 8, width of the drop/fail statistics counters

Ports:
PCLK  in  1  clock, rising edge
PRESET  in  1  reset, asynchronous, active-low
i_data  in  m  ALU result
i_data_valid  in  1  result present this cycle
i_dest  in  2  target peripheral 0..3 (maps to PSEL0..PSEL3)
i_check_en  in  1  request read-back verify for this result
i_alu_error  in  1  result is invalid; qualifies i_data_valid
o_ready  out  1  FIFO can accept (not full)
o_apb_data  out  m  to master i_data
o_apb_data_ready  out  1  to master i_data_ready (start pulse)
o_apb_sel  out  2  to master i_protocol_sel
o_apb_check  out  1  to master i_data_check
i_apb_waiting  in  1  master o_waiting (idle, ready for work)
i_apb_done  in  1  master o_transfer_done (1-cycle pulse)
i_apb_fail  in  1  read-back mismatch, valid with i_apb_done in CHECK
o_busy  out  1  FIFO non-empty or FSM not IDLE
o_drop_cnt  out  CNT_W  results discarded (ALU error or FIFO full)
o_fail_cnt  out  CNT_W  entries abandoned after MAX_RETRY

Behaviour:
- Reset (PRESET=0, async): FIFO empty, FSM IDLE, retry count 0, both counters 0; o_ready=1; all o_apb_* =0; o_busy=0.
- Push: i_data_valid & ~i_alu_error & o_ready writes {i_data, i_dest, i_check_en} on the clock edge. i_data_valid & i_alu_error: no push, o_drop_cnt+1. i_data_valid & full: no push, o_drop_cnt+1. Counters saturate at all-ones.
- Simultaneous push and pop while full: the pop frees the slot only on the next cycle; o_ready is registered from occupancy, so the push is dropped.
- FSM states:
  - IDLE: FIFO non-empty & i_apb_waiting -> ISSUE.
  - ISSUE: 1 cycle. o_apb_data_ready=1, o_apb_check=0 -> WAIT_WR.
  - WAIT_WR: i_apb_done -> if head.check_en then CHECK, else POP.
  - CHECK: o_apb_check=1 held until i_apb_done. On i_apb_done: i_apb_fail=0 -> POP. i_apb_fail=1 & retry<MAX_RETRY -> retry+1, RETRY. i_apb_fail=1 & retry==MAX_RETRY -> o_fail_cnt+1, POP.
  - RETRY: wait i_apb_waiting -> ISSUE.
  - POP: 1 cycle. Head removed, retry cleared -> IDLE.
- o_apb_data and o_apb_sel show the FIFO head in every non-IDLE state and stay stable until POP. In IDLE they are 0.
- Minimum per-entry latency, FIFO head to pop: 3 cycles plus master transfer time.
- i_apb_done in IDLE, ISSUE, RETRY or POP: ignored.
- Pointers wrap modulo DEPTH. Occupancy counter is 0..DEPTH; full = DEPTH, empty = 0.
- Reset asserted mid-transfer: FIFO contents lost, all outputs return to reset values immediately (async).

Decomposition:
- Package apb_sched_pkg: state enum (IDLE, ISSUE, WAIT_WR, CHECK, RETRY, POP), entry struct {data, dest, check_en}.
- One sub-module: apb_sched_fifo, a sync FIFO of entry structs with push, pop, full, empty and count.

Test Plan:
- Single entry, no check: push 8'hC9, dest 2, i_apb_waiting=1. Expect o_apb_data_ready pulse 1 cycle later with o_apb_data=C9 and o_apb_sel=2. Done pulse -> POP, o_busy=0.
- Check passes: push 8'h5A, check_en=1. After write done, o_apb_check=1 until done with i_apb_fail=0. One ISSUE pulse only; o_fail_cnt=0.
- Retry exhaustion: MAX_RETRY=2, i_apb_fail always 1. Expect exactly 3 ISSUE pulses, then o_fail_cnt=1 and the entry is popped.
- Fill and overflow: 6 pushes while the master is held busy (i_apb_waiting=0). o_ready=0 after the 4th push; o_drop_cnt=2. Entries drain in FIFO order with the correct dest each.
- ALU error: i_data_valid=1, i_alu_error=1. No push, o_drop_cnt+1, o_busy stays 0.
- Reset mid-CHECK: PRESET low during CHECK. All outputs 0 at once; after release, o_ready=1, counters 0, FIFO empty.
